// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - interrupt sequencer: edge capture, priority select, vector entry
// IDLE -> ARM -> ENTER -> ISR, each step gated by the shared pipeline advance enable.
module irq_controller #(
   parameter int          N_SRC      = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0018,
   parameter logic [31:0] VEC_STRIDE = 32'd4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_SRC-1:0] i_irq,
   input  logic [N_SRC-1:0] i_irq_mask,
   input  logic             i_ret,
   input  logic             i_pc_en,
   output logic             o_int_mode,
   output logic [1:0]       o_irq_bak,
   output logic [31:0]      o_irq_r0,
   output logic [31:0]      o_irq_r1,
   output logic             o_pc_en,
   output logic [31:0]      o_pc_reg,
   output logic             o_flush,
   output logic             o_busy
);

   localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARM   = 2'd1;
   localparam logic [1:0] S_ENTER = 2'd2;
   localparam logic [1:0] S_ISR   = 2'd3;

   logic [1:0]       state;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] irq_q;
   logic [N_SRC-1:0] snap_q;
   logic [ID_W-1:0]  sel_q;
   logic [ID_W-1:0]  win_id;
   logic             any_req;
   logic [N_SRC-1:0] req;
   logic [N_SRC-1:0] clr;

   assign req = pending & ~i_irq_mask;

   // Descending scan so the lowest-numbered requester is the last one written.
   always_comb begin
      any_req = 1'b0;
      win_id  = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (req[k]) begin
            any_req = 1'b1;
            win_id  = ID_W'(k);
         end
      end
   end

   assign clr = (en && state == S_ENTER) ? (N_SRC'(1) << sel_q) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pending <= '0;
         irq_q   <= '1;
         sel_q   <= '0;
         snap_q  <= '0;
      end else begin
         irq_q   <= i_irq;
         // A fresh edge on the line being cleared wins over the clear.
         pending <= (pending & ~clr) | (i_irq & ~irq_q);
         if (en) begin
            case (state)
               S_IDLE: begin
                  if (any_req && !i_ret) begin
                     sel_q  <= win_id;
                     snap_q <= pending;
                     state  <= S_ARM;
                  end
               end
               S_ARM:   state <= S_ENTER;
               S_ENTER: state <= S_ISR;
               S_ISR:   if (i_ret) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      o_int_mode = (state == S_ISR);
      o_pc_en    = (state == S_ENTER);
      o_flush    = (state == S_ENTER);
      o_busy     = (state != S_IDLE);
      o_irq_bak  = 2'b00;
      if (state == S_ENTER) o_irq_bak = i_pc_en ? 2'b11 : 2'b10;
      if (state == S_IDLE) begin
         o_irq_r0 = 32'(win_id);
         o_irq_r1 = 32'(pending);
      end else begin
         o_irq_r0 = 32'(sel_q);
         o_irq_r1 = 32'(snap_q);
      end
      o_pc_reg = VEC_BASE + VEC_STRIDE * 32'(sel_q);
   end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller against a behavioural model
// Driver pushes per-cycle and per-entry expectations; a negedge monitor pops and compares.
module tb_irq_controller;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst, en, ret, pc_en;
   logic [N-1:0]  irq, mask;
   logic          o_int_mode, o_pc_en, o_flush, o_busy;
   logic [1:0]    o_irq_bak;
   logic [31:0]   o_irq_r0, o_irq_r1, o_pc_reg;

   always #5 clk = ~clk;

   irq_controller #(.N_SRC(N), .VEC_BASE(32'h0000_0018), .VEC_STRIDE(32'd4)) dut (
      .clk(clk), .rst(rst), .en(en), .i_irq(irq), .i_irq_mask(mask),
      .i_ret(ret), .i_pc_en(pc_en), .o_int_mode(o_int_mode), .o_irq_bak(o_irq_bak),
      .o_irq_r0(o_irq_r0), .o_irq_r1(o_irq_r1), .o_pc_en(o_pc_en), .o_pc_reg(o_pc_reg),
      .o_flush(o_flush), .o_busy(o_busy)
   );

   typedef struct {
      bit          busy, int_mode, entering, chk_r;
      bit [31:0]   r0, r1;
   } cyc_t;

   typedef struct {
      bit [31:0]   pc;
      bit [1:0]    bak;
   } entry_t;

   cyc_t   cyc_q[$];
   entry_t entry_q[$];
   int     checks = 0;
   int     errors = 0;
   int     n_entries = 0;

   // Model: phase 0 idle, 1 armed, 2 redirecting, 3 servicing
   bit [N-1:0] m_pend, m_hist, m_snap;
   int         m_sel, m_phase;

   function automatic int lowest_set(bit [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_hist = '1; m_snap = '0; m_sel = 0; m_phase = 0;
   endtask

   // Push what the DUT must show during the current cycle, then step the model across the next edge.
   task automatic tick();
      cyc_t   c;
      entry_t e;
      bit [N-1:0] edges;
      int w;
      w = lowest_set(m_pend & ~mask);
      c.busy = (m_phase != 0);
      c.int_mode = (m_phase == 3);
      c.entering = (m_phase == 2);
      c.chk_r = (m_phase != 3);
      if (m_phase == 0) begin
         c.r0 = (w < 0) ? 0 : w;
         c.r1 = 32'(m_pend);
      end else begin
         c.r0 = m_sel;
         c.r1 = 32'(m_snap);
      end
      cyc_q.push_back(c);
      if (m_phase == 2) begin
         e.pc = 32'h18 + 32'(m_sel) * 4;
         e.bak = pc_en ? 2'b11 : 2'b10;
         entry_q.push_back(e);
      end
      if (rst) model_reset();
      else begin
         edges = irq & ~m_hist;
         m_hist = irq;
         if (en) begin
            if (m_phase == 0) begin
               if (w >= 0 && !ret) begin
                  m_sel = w; m_snap = m_pend; m_phase = 1;
               end
            end else if (m_phase == 1) m_phase = 2;
            else if (m_phase == 2) begin
               m_pend[m_sel] = 1'b0; m_phase = 3;
            end else if (ret) m_phase = 0;
         end
         m_pend |= edges;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   always @(negedge clk) begin
      cyc_t   c;
      entry_t e;
      if (cyc_q.size() > 0) begin
         c = cyc_q.pop_front();
         check("o_busy", o_busy, c.busy);
         check("o_int_mode", o_int_mode, c.int_mode);
         check("o_pc_en", o_pc_en, c.entering);
         check("o_flush", o_flush, c.entering);
         if (!c.entering) check("o_irq_bak_idle", o_irq_bak, 2'b00);
         if (c.chk_r) begin
            check("o_irq_r0", o_irq_r0, c.r0);
            check("o_irq_r1", o_irq_r1, c.r1);
         end
         if (o_pc_en === 1'b1) begin
            if (entry_q.size() == 0) check("unexpected_entry", 1, 0);
            else begin
               e = entry_q.pop_front();
               n_entries++;
               check("o_pc_reg", o_pc_reg, e.pc);
               check("o_irq_bak", o_irq_bak, e.bak);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b1; ret = 1'b0; pc_en = 1'b0; irq = 4'b0010; mask = '0;
      model_reset();
      @(posedge clk);
      #1;
      // Line already high through reset must never fire
      ticks(3);
      rst = 1'b0;
      ticks(20);
      // Single source 2 entry and return
      irq = 4'b0000; tick();
      irq = 4'b0100; ticks(6);
      ret = 1'b1; tick();
      ret = 1'b0; ticks(2);
      // Sources 3 and 1 together: 1 first, 3 after return
      irq = 4'b0000; tick();
      irq = 4'b1010; ticks(6);
      ret = 1'b1; tick();
      ret = 1'b0; ticks(8);
      ret = 1'b1; tick();
      ret = 1'b0; ticks(3);
      // Stall in ARM, then branch in flight during ENTER
      irq = 4'b0000; tick();
      irq = 4'b0001; ticks(2);
      en = 1'b0; ticks(3);
      en = 1'b1; tick();
      pc_en = 1'b1; tick();
      pc_en = 1'b0; ticks(2);
      ret = 1'b1; tick();
      ret = 1'b0; ticks(2);
      // Masked source, unmask, reset inside the ISR
      mask = 4'b0001; irq = 4'b0000; tick();
      irq = 4'b0001; ticks(6);
      mask = 4'b0000; ticks(5);
      rst = 1'b1; tick();
      rst = 1'b0; ticks(4);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         en    = ($urandom_range(0, 9) < 8);
         ret   = ($urandom_range(0, 7) == 0);
         pc_en = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) irq[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 49) == 0) mask = N'($urandom);
         rst   = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0; en = 1'b1; ret = 1'b0;
      ticks(2);
      @(negedge clk);
      #1;
      check("entries_drained", entry_q.size(), 0);
      check("entries_seen", (n_entries > 5), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
